// File: rtl/cpu_trace_emitter_if.sv
`default_nettype none
// =============================================================================
// cpu_trace_emitter_if: record-in / character-out bus of the trace emitter.
// Rev 1.0
// =============================================================================
interface cpu_trace_emitter_if;
   logic        in_valid;
   logic        in_ready;
   logic        kind;
   // "time" is a reserved word, so the cycle stamp is carried as time_stamp
   logic [13:0] time_stamp;
   logic [31:0] pc;
   logic [4:0]  grf;
   logic [31:0] addr;
   logic [31:0] data;
   logic [7:0]  char;
   logic        char_valid;

   modport master (
      output in_valid, kind, time_stamp, pc, grf, addr, data,
      input  in_ready, char, char_valid
   );

   modport slave (
      input  in_valid, kind, time_stamp, pc, grf, addr, data,
      output in_ready, char, char_valid
   );
endinterface
`default_nettype wire

// File: rtl/cpu_trace_emitter.sv
`default_nettype none
// =============================================================================
// cpu_trace_emitter: serializes register/memory write records as ASCII lines.
// Optional macro TRACE_ZERO_STRIP_EN drops leading zeros of TIME.  Rev 1.0
// =============================================================================
module cpu_trace_emitter #(
   parameter int HEX_UPPER = 0
) (
   input  logic               clk,
   input  logic               reset,
   cpu_trace_emitter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      EMIT = 2'd2
   } state_t;

   localparam logic [3:0]  C_CONV_LAST = 4'd13;
   localparam logic [13:0] C_TIME_MAX  = 14'd9999;

   state_t      r_state;
   logic        r_kind;
   logic [31:0] r_pc;
   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic [13:0] r_tbin;
   logic [13:0] r_gbin;
   logic [15:0] r_tbcd;
   logic [7:0]  r_gbcd;
   logic [3:0]  r_cnt;
   logic [5:0]  r_idx;
   logic [7:0]  r_char;
   logic        r_char_valid;

   logic [2:0]  w_tn;
   logic [1:0]  w_tdig;
   logic [5:0]  w_last;
   logic [5:0]  w_next_idx;
   logic [5:0]  w_j;
   logic [5:0]  w_k;
   logic [7:0]  w_char;
   logic [15:0] w_tbcd_adj;
   logic [7:0]  w_gbcd_adj;

   function automatic logic [7:0] dec_char(input logic [3:0] n);
      return 8'h30 + {4'h0, n};
   endfunction

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      if (n < 4'd10)
         return 8'h30 + {4'h0, n};
      else if (HEX_UPPER != 0)
         return 8'h37 + {4'h0, n};
      else
         return 8'h57 + {4'h0, n};
   endfunction

   function automatic logic [3:0] nib(input logic [31:0] word, input logic [2:0] pos);
      return word[{pos, 2'b00} +: 4];
   endfunction

   // Double-dabble correction applied before every shift of the BCD registers
   always_comb begin
      w_tbcd_adj = r_tbcd;
      for (int i = 0; i < 4; i++) begin
         if (r_tbcd[4*i +: 4] > 4'd4)
            w_tbcd_adj[4*i +: 4] = r_tbcd[4*i +: 4] + 4'd3;
      end
      w_gbcd_adj = r_gbcd;
      for (int i = 0; i < 2; i++) begin
         if (r_gbcd[4*i +: 4] > 4'd4)
            w_gbcd_adj[4*i +: 4] = r_gbcd[4*i +: 4] + 4'd3;
      end
   end

`ifdef TRACE_ZERO_STRIP_EN
   assign w_tn = (r_tbcd[15:12] != 4'd0) ? 3'd4 :
                 (r_tbcd[11:8]  != 4'd0) ? 3'd3 :
                 (r_tbcd[7:4]   != 4'd0) ? 3'd2 : 3'd1;
`else
   assign w_tn = 3'd4;
`endif

   // Positions after TIME are counted from '@' (w_j) and from the ' ' before
   // "<=" (w_k), so both record kinds share one character map.
   assign w_next_idx = r_idx + 6'd1;
   assign w_last     = {3'b000, w_tn} + (r_kind ? 6'd33 : 6'd27);
   assign w_j        = r_idx - {3'b000, w_tn};
   assign w_k        = w_j - (r_kind ? 6'd20 : 6'd14);
   assign w_tdig     = 2'(w_tn - w_next_idx[2:0]);

   always_comb begin
      w_char = 8'h00;
      if (w_next_idx <= {3'b000, w_tn})
         w_char = dec_char(r_tbcd[{w_tdig, 2'b00} +: 4]);
      else if (w_j == 6'd0)
         w_char = "@";
      else if (w_j <= 6'd8)
         w_char = hex_char(nib(r_pc, 3'(6'd8 - w_j)));
      else if (w_j == 6'd9)
         w_char = ":";
      else if (w_j == 6'd10)
         w_char = " ";
      else if (w_j == 6'd11)
         w_char = r_kind ? "*" : "$";
      else if (!r_kind && (w_j == 6'd12))
         w_char = dec_char(r_gbcd[7:4]);
      else if (!r_kind && (w_j == 6'd13))
         w_char = dec_char(r_gbcd[3:0]);
      else if (r_kind && (w_j <= 6'd19))
         w_char = hex_char(nib(r_addr, 3'(6'd19 - w_j)));
      else begin
         case (w_k)
            6'd0:    w_char = " ";
            6'd1:    w_char = "<";
            6'd2:    w_char = "=";
            6'd3:    w_char = " ";
            6'd12:   w_char = "#";
            default: w_char = hex_char(nib(r_data, 3'(6'd11 - w_k)));
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_kind       <= 1'b0;
         r_pc         <= 32'h0;
         r_addr       <= 32'h0;
         r_data       <= 32'h0;
         r_tbin       <= 14'h0;
         r_gbin       <= 14'h0;
         r_tbcd       <= 16'h0;
         r_gbcd       <= 8'h0;
         r_cnt        <= 4'h0;
         r_idx        <= 6'h0;
         r_char       <= 8'h00;
         r_char_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_kind  <= bus.kind;
                  r_pc    <= bus.pc;
                  r_addr  <= bus.addr;
                  r_data  <= bus.data;
                  r_tbin  <= (bus.time_stamp > C_TIME_MAX) ? C_TIME_MAX : bus.time_stamp;
                  // grf rides in the low bits so it finishes on the same 14 shifts
                  r_gbin  <= {9'd0, bus.grf};
                  r_tbcd  <= 16'h0;
                  r_gbcd  <= 8'h0;
                  r_cnt   <= 4'h0;
                  r_state <= CONV;
               end
            end
            CONV: begin
               r_tbcd <= {w_tbcd_adj[14:0], r_tbin[13]};
               r_tbin <= {r_tbin[12:0], 1'b0};
               r_gbcd <= {w_gbcd_adj[6:0], r_gbin[13]};
               r_gbin <= {r_gbin[12:0], 1'b0};
               r_cnt  <= r_cnt + 4'd1;
               if (r_cnt == C_CONV_LAST) begin
                  r_state      <= EMIT;
                  r_idx        <= 6'd0;
                  r_char       <= "^";
                  r_char_valid <= 1'b1;
               end
            end
            EMIT: begin
               if (r_idx == w_last) begin
                  r_state      <= IDLE;
                  r_char       <= 8'h00;
                  r_char_valid <= 1'b0;
               end else begin
                  r_idx  <= w_next_idx;
                  r_char <= w_char;
               end
            end
            default: begin
               r_state      <= IDLE;
               r_char       <= 8'h00;
               r_char_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready   = (r_state == IDLE);
   assign bus.char       = r_char;
   assign bus.char_valid = r_char_valid;

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_emitter.sv
`default_nettype none
// =============================================================================
// tb_cpu_trace_emitter: checks lower- and upper-case hex builds against a
// string-formatting reference model.  Rev 1.0
// =============================================================================
module tb_cpu_trace_emitter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cpu_trace_emitter_if bus0 ();
    cpu_trace_emitter_if bus1 ();

    assign bus1.in_valid   = bus0.in_valid;
    assign bus1.kind       = bus0.kind;
    assign bus1.time_stamp = bus0.time_stamp;
    assign bus1.pc         = bus0.pc;
    assign bus1.grf        = bus0.grf;
    assign bus1.addr       = bus0.addr;
    assign bus1.data       = bus0.data;

    cpu_trace_emitter #(.HEX_UPPER(0)) u_dut_lo (.clk(clk), .reset(reset), .bus(bus0.slave));
    cpu_trace_emitter #(.HEX_UPPER(1)) u_dut_up (.clk(clk), .reset(reset), .bus(bus1.slave));

    typedef struct {
        bit          k;
        int          t;
        logic [31:0] pc;
        int          g;
        logic [31:0] a;
        logic [31:0] d;
    } rec_t;

    bit          e_kind;
    int          e_time;
    logic [31:0] e_pc;
    int          e_grf;
    logic [31:0] e_addr;
    logic [31:0] e_data;

    function automatic string model(input bit up);
        int    ts;
        string tstr;
        string s;
        ts = (e_time > 9999) ? 9999 : e_time;
`ifdef TRACE_ZERO_STRIP_EN
        tstr = $sformatf("%0d", ts);
`else
        tstr = $sformatf("%0d%0d%0d%0d", ts / 1000, (ts / 100) % 10, (ts / 10) % 10, ts % 10);
`endif
        if (!e_kind)
            s = $sformatf("^%s@%h: $%0d%0d <= %h#", tstr, e_pc, e_grf / 10, e_grf % 10, e_data);
        else
            s = $sformatf("^%s@%h: *%h <= %h#", tstr, e_pc, e_addr, e_data);
        if (up)
            s = s.toupper();
        return s;
    endfunction

    task automatic set_fields(input bit k, input int t, input logic [31:0] pc,
                              input int g, input logic [31:0] a, input logic [31:0] d);
        e_kind = k; e_time = t; e_pc = pc; e_grf = g; e_addr = a; e_data = d;
        bus0.kind       = k;
        bus0.time_stamp = 14'(t);
        bus0.pc         = pc;
        bus0.grf        = 5'(g);
        bus0.addr       = a;
        bus0.data       = d;
    endtask

    // Returns just after the accept edge.
    task automatic accept_record(output bit ok);
        int n = 0;
        @(negedge clk);
        bus0.in_valid = 1'b1;
        while (bus0.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (bus0.in_ready === 1'b1);
        @(posedge clk);
    endtask

    // Gathers one record; lat counts negedges from the accept edge to '^'.
    task automatic collect(input bit noise, input bit hold, output string s0, output string s1,
                           output int lat, output int bad);
        int c = 0;
        bit started = 1'b0;
        bit done = 1'b0;
        s0 = ""; s1 = ""; lat = -1; bad = 0;
        while (!done && c < 120) begin
            @(negedge clk);
            c++;
            if (bus1.char_valid !== bus0.char_valid) bad++;
            if (bus0.char_valid === 1'b1) begin
                if (!started) begin
                    started = 1'b1;
                    lat = c;
                end
                s0 = $sformatf("%s%c", s0, bus0.char);
                s1 = $sformatf("%s%c", s1, bus1.char);
                if (bus0.char == 8'h23) done = 1'b1;
            end else begin
                if (bus0.char !== 8'h00) bad++;
                if (started) begin
                    bad++;
                    done = 1'b1;
                end
            end
            if (noise) begin
                bus0.in_valid   = 1'($urandom);
                bus0.kind       = 1'($urandom);
                bus0.time_stamp = 14'($urandom);
                bus0.pc         = $urandom;
                bus0.grf        = 5'($urandom);
                bus0.addr       = $urandom;
                bus0.data       = $urandom;
            end
            if (done) bus0.in_valid = hold;
        end
        if (!done) bad++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus0.in_valid = 1'b0;
        set_fields(1'b0, 0, 32'h0, 0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        checks++;
        if (bus0.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b exp=1", bus0.in_ready);
        end
        checks++;
        if (bus0.char_valid !== 1'b0 || bus1.char_valid !== 1'b0) begin
            errors++; $display("FAIL reset_char_valid got=%b/%b exp=0", bus0.char_valid, bus1.char_valid);
        end
        checks++;
        if (bus0.char !== 8'h00) begin
            errors++; $display("FAIL reset_char got=%h exp=00", bus0.char);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        rec_t  tab[6];
        string s0, s1;
        int    lat, bad;
        bit    ok;
        tab[0] = '{1'b0, 1024,  32'h0000_3000, 9,  32'h0,         32'h0};
        tab[1] = '{1'b1, 3,     32'h0000_3004, 0,  32'h0000_0010, 32'hdead_beef};
        tab[2] = '{1'b0, 12345, 32'hffff_ffff, 31, 32'h0,         32'hffff_ffff};
        tab[3] = '{1'b0, 0,     32'h0,         0,  32'h0,         32'h0};
        tab[4] = '{1'b1, 9999,  32'hcafe_f00d, 5,  32'h8000_0001, 32'h0123_4567};
        tab[5] = '{1'b1, 10000, 32'h89ab_cdef, 17, 32'hfedc_ba98, 32'ha5a5_5a5a};
        foreach (tab[i]) begin
            set_fields(tab[i].k, tab[i].t, tab[i].pc, tab[i].g, tab[i].a, tab[i].d);
            accept_record(ok);
            #1 bus0.in_valid = 1'b0;
            collect(1'b0, 1'b0, s0, s1, lat, bad);
            checks++;
            if (!ok || lat != 15) begin
                errors++; $display("FAIL dir%0d_latency got=%0d exp=15 accepted=%b", i, lat, ok);
            end
            checks++;
            if (s0 != model(1'b0)) begin
                errors++; $display("FAIL dir%0d_lower got='%s' exp='%s'", i, s0, model(1'b0));
            end
            checks++;
            if (s1 != model(1'b1)) begin
                errors++; $display("FAIL dir%0d_upper got='%s' exp='%s'", i, s1, model(1'b1));
            end
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL dir%0d_stream got=%0d glitches exp=0", i, bad);
            end
            if (i == 0) begin
                checks++;
                if (s0 != "^1024@00003000: $09 <= 00000000#") begin
                    errors++; $display("FAIL dir0_literal got='%s' exp='^1024@00003000: $09 <= 00000000#'", s0);
                end
            end
            @(negedge clk);
            checks++;
            if (bus0.in_ready !== 1'b1 || bus0.char_valid !== 1'b0) begin
                errors++; $display("FAIL dir%0d_idle got ready=%b valid=%b exp ready=1 valid=0",
                                   i, bus0.in_ready, bus0.char_valid);
            end
        end
    endtask

    task automatic test_random();
        string s0, s1;
        int    lat, bad;
        bit    ok;
        for (int n = 0; n < 8; n++) begin
            set_fields(1'($urandom), int'($urandom_range(0, 16383)), $urandom,
                       int'($urandom_range(0, 31)), $urandom, $urandom);
            accept_record(ok);
            #1 bus0.in_valid = 1'b0;
            collect(1'b1, 1'b0, s0, s1, lat, bad);
            checks++;
            if (!ok || lat != 15) begin
                errors++; $display("FAIL rnd%0d_latency got=%0d exp=15 accepted=%b", n, lat, ok);
            end
            checks++;
            if (s0 != model(1'b0) || s1 != model(1'b1)) begin
                errors++; $display("FAIL rnd%0d_text got='%s'/'%s' exp='%s'", n, s0, s1, model(1'b0));
            end
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL rnd%0d_stream got=%0d glitches exp=0", n, bad);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        string s0, s1, exp0, exp1;
        int    lat, bad;
        bit    ok;
        set_fields(1'b1, 42, 32'h1111_2222, 0, 32'h3333_4444, 32'h5555_6666);
        exp0 = model(1'b0);
        exp1 = model(1'b1);
        accept_record(ok);
        // Inputs change right after capture while in_valid stays high
        #1 set_fields(1'b0, 777, 32'habcd_0123, 23, 32'h0, 32'h89ab_cdef);
        collect(1'b0, 1'b1, s0, s1, lat, bad);
        checks++;
        if (!ok || lat != 15 || bad != 0 || s0 != exp0 || s1 != exp1) begin
            errors++; $display("FAIL b2b_first got='%s' lat=%0d bad=%0d exp='%s'", s0, lat, bad, exp0);
        end
        @(negedge clk);
        checks++;
        if (bus0.in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_gap_ready got=%b exp=1", bus0.in_ready);
        end
        @(posedge clk);
        collect(1'b0, 1'b0, s0, s1, lat, bad);
        checks++;
        if (lat != 15) begin
            errors++; $display("FAIL b2b_second_latency got=%0d exp=15", lat);
        end
        checks++;
        if (s0 != model(1'b0) || s1 != model(1'b1) || bad != 0) begin
            errors++; $display("FAIL b2b_second got='%s' bad=%0d exp='%s'", s0, bad, model(1'b0));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        string s0, s1;
        int    lat, bad, seen, n;
        bit    ok;
        // Abort during conversion
        set_fields(1'b0, 55, 32'h1234_5678, 3, 32'h0, 32'h9abc_def0);
        accept_record(ok);
        #1 bus0.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus0.in_ready !== 1'b1 || bus0.char_valid !== 1'b0) begin
            errors++; $display("FAIL abort_conv got ready=%b valid=%b exp ready=1 valid=0",
                               bus0.in_ready, bus0.char_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus0.char_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL abort_conv_resume got=%0d chars exp=0", seen);
        end
        // Abort at the 10th emitted character
        set_fields(1'b1, 8765, 32'h0bad_cafe, 0, 32'h0000_4000, 32'h7777_8888);
        accept_record(ok);
        #1 bus0.in_valid = 1'b0;
        seen = 0;
        n = 0;
        while (seen < 10 && n < 60) begin
            @(negedge clk);
            n++;
            if (bus0.char_valid === 1'b1) seen++;
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus0.char_valid !== 1'b0 || bus0.char !== 8'h00 || bus0.in_ready !== 1'b1 || seen != 10) begin
            errors++; $display("FAIL abort_emit got valid=%b char=%h ready=%b seen=%0d exp valid=0 char=00 ready=1 seen=10",
                               bus0.char_valid, bus0.char, bus0.in_ready, seen);
        end
        @(negedge clk);
        reset = 1'b0;
        set_fields(1'b0, 321, 32'h0000_00ff, 30, 32'h0, 32'hffff_0000);
        accept_record(ok);
        #1 bus0.in_valid = 1'b0;
        collect(1'b0, 1'b0, s0, s1, lat, bad);
        checks++;
        if (!ok || lat != 15 || bad != 0 || s0 != model(1'b0) || s1 != model(1'b1)) begin
            errors++; $display("FAIL abort_recover got='%s' lat=%0d bad=%0d exp='%s'", s0, lat, bad, model(1'b0));
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        bus0.in_valid = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_trace_emitter.md
CPU_TRACE_EMITTER -- requirements
Module: cpu_trace_emitter

Interface
REQ-001 Parameter HEX_UPPER, default 0; 0 = hex digits a-f, 1 = hex digits A-F.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  a record is presented on the field inputs.
REQ-005 in_ready  output  1  emitter can accept a record; high only in IDLE.
REQ-006 kind  input  1  record type; 0 = register write, 1 = memory write.
REQ-007 time  input  14  binary cycle stamp.
REQ-008 pc  input  32  instruction address.
REQ-009 grf  input  5  register index, used only when kind=0.
REQ-010 addr  input  32  memory address, used only when kind=1.
REQ-011 data  input  32  written value.
REQ-012 char  output  8  ASCII character; 8'h00 whenever char_valid=0.
REQ-013 char_valid  output  1  char carries a record character this cycle.

Function
REQ-014 The block SHALL serialize one record per handshake, one character per cycle.
REQ-015 Register record format: '^' TIME '@' PC8 ':' ' ' '$' GRF2 ' ' '<' '=' ' ' DATA8 '#', 32 characters.
REQ-016 Memory record format: '^' TIME '@' PC8 ':' ' ' '*' ADDR8 ' ' '<' '=' ' ' DATA8 '#', 38 characters.
REQ-017 PC8, ADDR8 and DATA8 SHALL be 8 hex digits, MSB first, zero-padded; GRF2 SHALL be 2 decimal digits (00-31); TIME SHALL be 4 decimal digits.
REQ-018 A time value above 9999 SHALL saturate to 9999.
REQ-019 FSM states: IDLE, CONV, EMIT.
REQ-020 IDLE -> CONV occurs on the edge where in_valid=1 and in_ready=1; all field inputs are captured on that edge, and later input changes have no effect.
REQ-021 CONV SHALL run a sequential shift-add-3 (double-dabble) binary-to-BCD conversion of time and grf for exactly 14 cycles, then go to EMIT.
REQ-022 In EMIT, char_valid=1 on every cycle; the first character '^' appears in the cycle after CONV ends, i.e. 15 cycles after the accept edge.
REQ-023 After the cycle that presents '#', the FSM SHALL return to IDLE, with in_ready=1 in the next cycle; there are no idle gaps inside a record.
REQ-024 in_valid while not IDLE SHALL be ignored and nothing is queued; the next accept is earliest 1 cycle after '#'.
REQ-025 char and char_valid SHALL be registered outputs; in_ready SHALL be decoded from state.

Reset
REQ-026 Reset SHALL force state=IDLE, char=8'h00, char_valid=0 and in_ready=1, and clear all capture and BCD registers.
REQ-027 Reset asserted mid-CONV or mid-EMIT SHALL abort the record immediately; the partial record is never resumed.

Configuration
REQ-028 With macro TRACE_ZERO_STRIP_EN defined, TIME SHALL omit leading zeros (minimum 1 digit, so 0 -> "0") and the record length shrinks accordingly; GRF2 and the hex fields are unaffected.
REQ-029 Without TRACE_ZERO_STRIP_EN, TIME SHALL always be 4 digits as in REQ-017.

Verification
REQ-030 kind=0, time=1024, pc=32'h3000, grf=9, data=0 -> "^1024@00003000: $09 <= 00000000#"; '^' at accept+15; 32 consecutive char_valid cycles.
REQ-031 kind=1, time=3, pc=32'h3004, addr=32'h10, data=32'hdeadbeef -> "^0003@00003004: *00000010 <= deadbeef#" (HEX_UPPER=0); with HEX_UPPER=1 -> "...DEADBEEF#".
REQ-032 time=12345 -> TIME field "9999"; time=0 with TRACE_ZERO_STRIP_EN -> "^0@..." and 29 characters for kind=0.
REQ-033 in_valid held high for two records -> second accept exactly 1 cycle after the first '#'; in_valid pulses during CONV/EMIT are ignored.
REQ-034 reset pulse at the 10th EMIT character -> char_valid=0 and char=0 at once, in_ready=1; a new record then emits correctly from '^'.
